seven_segment_capture: RTL and testbench
========================================

Name: seven_segment_capture

Overview:
- Receive-side counterpart of the multiplexed 4-digit seven-segment driver. Watches the anode/segment bus, waits for each digit dwell to settle, and decodes the active-low segment pattern back to a 4-bit value.
- Assembles the four digits into a frame and presents it on a valid/ready handshake.
- Used as a loopback checker and as a scoreboard front-end for display verification.

Parameters:
- SETTLE_CYCLES, 1024: consecutive cycles with anode and segment both unchanged before a sample is taken.
- TIMEOUT_CYCLES, 65536: consecutive cycles without any anode change before stall asserts.

Ports:
- clk_100MHz  in  1: single clock, all logic on rising edge.
- reset  in  1: asynchronous, active-low reset.
- anode  in  4: active-low digit enables from the driver.
- segment  in  7: active-low segments {g,f,e,d,c,b,a}.
- frame_ready  in  1: consumer accepts the frame.
- frame_valid  out  1: frame available.
- digits  out  16: slot3..slot0, 4 bits each; slot0 = digits[3:0].
- dash_mask  out  4: per-slot flag, pattern was the dash 0111111.
- frame_error  out  1: frame contains an undecodable pattern or saw an illegal anode.
- stall  out  1: display scan stopped.

Behaviour:
- Reset (reset=0, async): all outputs 0, internal registers 0, state COLLECT, seen mask 0000.
- Input stage: anode and segment registered once. All detection uses the registered copies, so there is 1 cycle of input latency.
- Anode classes:
  - Exactly one zero = legal. 1110→slot0, 1101→slot1, 1011→slot2, 0111→slot3.
  - 1111 = blank. Settle counter held at 0, no sample taken.
  - More than one zero = illegal. Sets the sticky err_acc bit, settle counter held at 0.
- Settle counter ($clog2(SETTLE_CYCLES) bits, saturating):
  - Restarts at 0 on any change of registered anode or segment.
  - A change also re-arms sampling for the current dwell.
  - When the count reaches SETTLE_CYCLES-1 on a legal anode and the dwell is armed: sample once and disarm until the next change.
  - A later re-settle within the same anode overwrites that slot.
- Decode table:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9.
  - 0111111 → value 4'hA and dash bit set.
  - Any other pattern → value 4'hF and err_acc set.
- Sample effect: write the slot's value and dash bit into shadow registers; set seen[slot].
- FSM COLLECT:
  - Sample when seen becomes 1111 (including the completing sample that cycle): copy shadow→digits/dash_mask, err_acc→frame_error, set frame_valid=1, enter HOLD.
- FSM HOLD:
  - Outputs frozen; samples and errors are ignored.
  - Transfer occurs at a rising edge with frame_valid=1 and frame_ready=1.
  - Next cycle: frame_valid=0, seen=0000, err_acc=0, shadow cleared, enter COLLECT. digits, dash_mask and frame_error keep their last value until the next frame.
  - frame_ready while frame_valid=0 has no effect.
- Stall:
  - Timeout counter ($clog2(TIMEOUT_CYCLES)+1 bits) counts cycles since the last registered anode change, saturating.
  - When the count reaches TIMEOUT_CYCLES: stall=1. In COLLECT, this also clears seen and err_acc (partial frame discarded).
  - stall=0 on the cycle after the next anode change.
  - In HOLD, stall still reports but the held frame is kept.
- Ordering: slots may complete in any order and a slot may be sampled repeatedly. Only full coverage of all four slots triggers a frame.

Test Plan:
- Reset: assert reset=0 mid-collection with seen=0011 → all outputs 0 immediately; after release, a full 4-slot scan is needed before frame_valid.
- Nominal frame, frame_ready tied 1, 2000 cycles per dwell:
  - Stimulus: 1110/1111001, 1101/0100100, 1011/0110000, 0111/1000000.
  - Response: frame_valid pulses one cycle with digits=16'h0321, dash_mask=0000, frame_error=0.
- Backpressure:
  - Stimulus: as above with frame_ready=0 for 500 cycles, while driving a second scan showing 9,8,7,6.
  - Response: digits stays 16'h0321. After a ready pulse, frame_valid=0 next cycle. A later full scan yields 16'h6789.
- Glitch:
  - Stimulus: 1110 held 500 cycles (less than SETTLE_CYCLES), then 1101/1011/0111 settled.
  - Response: no frame. After 1110 is later held 2000 cycles, the frame is emitted.
- Error/dash:
  - Stimulus: anode 1100 for 2000 cycles, slot2 showing 0111111, slot1 showing 1010101, remaining slots legal.
  - Response: frame_error=1, dash_mask=0100, digits[11:8]=4'hA, digits[7:4]=4'hF.
- Stall:
  - Stimulus: hold 1110 for 70000 cycles with seen=0110.
  - Response: stall=1 at 65536 cycles after the last change, seen cleared. An anode change clears stall the next cycle, and no frame is emitted without 4 new slots.

Source files
------------

// File: rtl/seven_segment_capture.sv
// Receive-side decoder for a multiplexed 4-digit seven-segment bus: waits for each
// digit dwell to settle, decodes it, and presents complete 4-slot frames on valid/ready.
module seven_segment_capture #(
  parameter int SETTLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [6:0]  segment,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [15:0] digits,
  output logic [3:0]  dash_mask,
  output logic        frame_error,
  output logic        stall
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_PRE = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_COLLECT, S_HOLD} state_t;

  state_t        r_state, w_state_next;
  logic [3:0]    r_anode;
  logic [6:0]    r_segment;
  logic          r_in_valid;
  logic [SW-1:0] r_settle, w_settle_next;
  logic          r_armed, w_armed_next;
  logic [TW-1:0] r_timeout, w_timeout_next;
  logic [3:0]    r_seen, w_seen_next;
  logic          r_err_acc, w_err_acc_next;
  logic [15:0]   r_shadow_digits, w_shadow_digits_next;
  logic [3:0]    r_shadow_dash, w_shadow_dash_next;
  logic          r_frame_valid, w_frame_valid_next;
  logic [15:0]   r_digits, w_digits_next;
  logic [3:0]    r_dash_mask, w_dash_mask_next;
  logic          r_frame_error, w_frame_error_next;

  logic       w_anode_change, w_change;
  logic       w_legal, w_blank, w_illegal;
  logic [1:0] w_slot;
  logic [3:0] w_value;
  logic       w_dash, w_bad;
  logic       w_sample, w_timeout_hit;

  assign w_anode_change = (anode != r_anode);
  assign w_change       = w_anode_change || (segment != r_segment);

  // r_in_valid keeps the all-zero reset value of r_anode from reading as an illegal anode
  always_comb begin
    w_legal = 1'b0;
    w_slot  = 2'd0;
    case (r_anode)
      4'b1110: begin w_legal = r_in_valid; w_slot = 2'd0; end
      4'b1101: begin w_legal = r_in_valid; w_slot = 2'd1; end
      4'b1011: begin w_legal = r_in_valid; w_slot = 2'd2; end
      4'b0111: begin w_legal = r_in_valid; w_slot = 2'd3; end
      default: ;
    endcase
  end

  assign w_blank   = (r_anode == 4'b1111);
  assign w_illegal = r_in_valid && !w_legal && !w_blank;

  always_comb begin
    w_value = 4'hF;
    w_dash  = 1'b0;
    w_bad   = 1'b0;
    case (r_segment)
      7'b1000000: w_value = 4'd0;
      7'b1111001: w_value = 4'd1;
      7'b0100100: w_value = 4'd2;
      7'b0110000: w_value = 4'd3;
      7'b0011001: w_value = 4'd4;
      7'b0010010: w_value = 4'd5;
      7'b0000010: w_value = 4'd6;
      7'b1111000: w_value = 4'd7;
      7'b0000000: w_value = 4'd8;
      7'b0010000: w_value = 4'd9;
      7'b0111111: begin w_value = 4'hA; w_dash = 1'b1; end
      default:    w_bad = 1'b1;
    endcase
  end

  assign w_sample      = w_legal && r_armed && (r_settle == SETTLE_MAX);
  assign w_timeout_hit = !w_anode_change && (r_timeout == TIMEOUT_PRE);

  always_comb begin
    w_state_next         = r_state;
    w_seen_next          = r_seen;
    w_err_acc_next       = r_err_acc;
    w_shadow_digits_next = r_shadow_digits;
    w_shadow_dash_next   = r_shadow_dash;
    w_frame_valid_next   = r_frame_valid;
    w_digits_next        = r_digits;
    w_dash_mask_next     = r_dash_mask;
    w_frame_error_next   = r_frame_error;

    if (w_change || !w_legal)
      w_settle_next = '0;
    else if (r_settle == SETTLE_MAX)
      w_settle_next = r_settle;
    else
      w_settle_next = r_settle + 1'b1;

    if (w_anode_change)
      w_timeout_next = '0;
    else if (r_timeout == TIMEOUT_MAX)
      w_timeout_next = r_timeout;
    else
      w_timeout_next = r_timeout + 1'b1;

    // A dwell is sampled once; any input change re-arms it
    if (w_change)
      w_armed_next = 1'b1;
    else if (w_sample)
      w_armed_next = 1'b0;
    else
      w_armed_next = r_armed;

    case (r_state)
      S_COLLECT: begin
        if (w_illegal)
          w_err_acc_next = 1'b1;
        if (w_sample) begin
          w_shadow_digits_next[{w_slot, 2'b00} +: 4] = w_value;
          w_shadow_dash_next[w_slot]                 = w_dash;
          w_seen_next[w_slot]                        = 1'b1;
          if (w_bad)
            w_err_acc_next = 1'b1;
        end
        if (w_timeout_hit) begin
          w_seen_next    = 4'b0000;
          w_err_acc_next = 1'b0;
        end else if (w_seen_next == 4'b1111) begin
          w_digits_next      = w_shadow_digits_next;
          w_dash_mask_next   = w_shadow_dash_next;
          w_frame_error_next = w_err_acc_next;
          w_frame_valid_next = 1'b1;
          w_state_next       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_frame_valid && frame_ready) begin
          w_frame_valid_next   = 1'b0;
          w_seen_next          = 4'b0000;
          w_err_acc_next       = 1'b0;
          w_shadow_digits_next = '0;
          w_shadow_dash_next   = '0;
          w_state_next         = S_COLLECT;
        end
      end
      default: w_state_next = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_state         <= S_COLLECT;
      r_anode         <= '0;
      r_segment       <= '0;
      r_in_valid      <= 1'b0;
      r_settle        <= '0;
      r_armed         <= 1'b0;
      r_timeout       <= '0;
      r_seen          <= '0;
      r_err_acc       <= 1'b0;
      r_shadow_digits <= '0;
      r_shadow_dash   <= '0;
      r_frame_valid   <= 1'b0;
      r_digits        <= '0;
      r_dash_mask     <= '0;
      r_frame_error   <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_anode         <= anode;
      r_segment       <= segment;
      r_in_valid      <= 1'b1;
      r_settle        <= w_settle_next;
      r_armed         <= w_armed_next;
      r_timeout       <= w_timeout_next;
      r_seen          <= w_seen_next;
      r_err_acc       <= w_err_acc_next;
      r_shadow_digits <= w_shadow_digits_next;
      r_shadow_dash   <= w_shadow_dash_next;
      r_frame_valid   <= w_frame_valid_next;
      r_digits        <= w_digits_next;
      r_dash_mask     <= w_dash_mask_next;
      r_frame_error   <= w_frame_error_next;
    end
  end

  assign frame_valid = r_frame_valid;
  assign digits      = r_digits;
  assign dash_mask   = r_dash_mask;
  assign frame_error = r_frame_error;
  assign stall       = (r_timeout == TIMEOUT_MAX);

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture with shortened settle/timeout windows
// so the whole plan fits in a few thousand cycles.
module tb_seven_segment_capture;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 256;
  localparam int DWELL   = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  anode = 4'b1111;
  logic [6:0]  segment = 7'b1111111;
  logic        frame_ready = 1'b1;
  logic        frame_valid;
  logic [15:0] digits;
  logic [3:0]  dash_mask;
  logic        frame_error;
  logic        stall;

  int errors = 0;
  int checks = 0;
  int frames = 0;
  logic prev_valid = 1'b0;

  seven_segment_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_100MHz (clk),
    .reset      (reset_n),
    .anode      (anode),
    .segment    (segment),
    .frame_ready(frame_ready),
    .frame_valid(frame_valid),
    .digits     (digits),
    .dash_mask  (dash_mask),
    .frame_error(frame_error),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  // Count frames as rising edges of frame_valid, sampled just after each clock edge
  always @(posedge clk) begin
    #1;
    if (frame_valid && !prev_valid)
      frames++;
    prev_valid = frame_valid;
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b1000000;
      1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;
      3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;
      5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;
      7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;
      default: seg_of = 7'b0010000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] sg, input int n);
    anode   = an;
    segment = sg;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input int d0, input int d1, input int d2, input int d3);
    dwell(4'b1110, seg_of(d0), DWELL);
    dwell(4'b1101, seg_of(d1), DWELL);
    dwell(4'b1011, seg_of(d2), DWELL);
    dwell(4'b0111, seg_of(d3), DWELL);
    dwell(4'b1111, 7'b1111111, 4);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_valid", 16'(frame_valid), 16'h0);
    chk("reset_digits", digits, 16'h0000);
    chk("reset_dash", 16'(dash_mask), 16'h0);
    chk("reset_error", 16'(frame_error), 16'h0);
    chk("reset_stall", 16'(stall), 16'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Nominal frame, ready held high: one-cycle pulse
    scan(1, 2, 3, 0);
    chk("nom_frames", 16'(frames), 16'd1);
    chk("nom_digits", digits, 16'h0321);
    chk("nom_dash", 16'(dash_mask), 16'h0);
    chk("nom_error", 16'(frame_error), 16'h0);
    chk("nom_valid_dropped", 16'(frame_valid), 16'h0);

    // Backpressure: second scan during HOLD must be ignored
    frame_ready = 1'b0;
    scan(1, 2, 3, 0);
    scan(9, 8, 7, 6);
    chk("bp_frames", 16'(frames), 16'd2);
    chk("bp_valid_held", 16'(frame_valid), 16'h1);
    chk("bp_digits_held", digits, 16'h0321);
    frame_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_after_ready", 16'(frame_valid), 16'h0);
    scan(9, 8, 7, 6);
    chk("bp_frames2", 16'(frames), 16'd3);
    chk("bp_digits2", digits, 16'h6789);

    // Glitch: short dwell on slot0 is not sampled
    dwell(4'b1110, seg_of(5), SETTLE / 2);
    dwell(4'b1101, seg_of(4), DWELL);
    dwell(4'b1011, seg_of(3), DWELL);
    dwell(4'b0111, seg_of(2), DWELL);
    chk("glitch_no_frame", 16'(frames), 16'd3);
    dwell(4'b1110, seg_of(5), DWELL);
    chk("glitch_frames", 16'(frames), 16'd4);
    chk("glitch_digits", digits, 16'h2345);

    // Illegal anode, dash and undecodable pattern
    dwell(4'b1100, 7'b1111111, DWELL);
    dwell(4'b1110, seg_of(1), DWELL);
    dwell(4'b1101, 7'b1010101, DWELL);
    dwell(4'b1011, 7'b0111111, DWELL);
    dwell(4'b0111, seg_of(0), DWELL);
    chk("err_frames", 16'(frames), 16'd5);
    chk("err_error", 16'(frame_error), 16'h1);
    chk("err_dash", 16'(dash_mask), 16'b0100);
    chk("err_slot2", 16'(digits[11:8]), 16'hA);
    chk("err_slot1", 16'(digits[7:4]), 16'hF);
    chk("err_digits", digits, 16'h0AF1);

    // Stall: slots 1,2 seen, then slot0 held past the timeout
    dwell(4'b1101, seg_of(4), DWELL);
    dwell(4'b1011, seg_of(5), DWELL);
    dwell(4'b1110, seg_of(7), TIMEOUT);
    chk("stall_before", 16'(stall), 16'h0);
    @(negedge clk);
    chk("stall_at_timeout", 16'(stall), 16'h1);
    repeat (40) @(negedge clk);
    chk("stall_sustained", 16'(stall), 16'h1);
    dwell(4'b0111, seg_of(0), 1);
    chk("stall_cleared", 16'(stall), 16'h0);
    repeat (DWELL - 1) @(negedge clk);
    chk("stall_partial_discarded", 16'(frames), 16'd5);
    dwell(4'b1110, seg_of(1), DWELL);
    dwell(4'b1101, seg_of(2), DWELL);
    dwell(4'b1011, seg_of(3), DWELL);
    chk("post_stall_frames", 16'(frames), 16'd6);
    chk("post_stall_digits", digits, 16'h0321);
    chk("post_stall_error", 16'(frame_error), 16'h0);
    chk("post_stall_dash", 16'(dash_mask), 16'h0);
    dwell(4'b1111, 7'b1111111, 4);

    // Asynchronous reset mid-collection with slots 0,1 seen
    dwell(4'b1110, seg_of(9), DWELL);
    dwell(4'b1101, seg_of(8), DWELL);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_digits", digits, 16'h0000);
    chk("mid_reset_valid", 16'(frame_valid), 16'h0);
    chk("mid_reset_stall", 16'(stall), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    dwell(4'b1011, seg_of(7), DWELL);
    dwell(4'b0111, seg_of(6), DWELL);
    dwell(4'b1111, 7'b1111111, 4);
    chk("mid_reset_no_frame", 16'(frames), 16'd6);
    scan(9, 8, 7, 6);
    chk("after_reset_frames", 16'(frames), 16'd7);
    chk("after_reset_digits", digits, 16'h6789);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
